fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one FIFO write port among `NUM_REQ` requesters. Each requester presents a word and holds it until granted. The arbiter sequences one write at a time into the FIFO and retries on overflow, so no word is lost. It sits directly in front of the FIFO's write-side signals (`data_in`, `wr_en`, `wr_ack`, `overflow`, `full`).

## Interface
- `FIFO_WIDTH`, 16, word width; matches FIFO data width
- `NUM_REQ`, 4, number of requesters (≥2)
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req` in `NUM_REQ`: per-requester request; held high until matching `gnt`
- `req_data` in `NUM_REQ*FIFO_WIDTH`: requester i's word at bits [i*FIFO_WIDTH +: FIFO_WIDTH]; stable while `req[i]` high
- `gnt` out `NUM_REQ`: one-hot, 1-cycle pulse: requester's word was acknowledged by FIFO
- `data_in` out `FIFO_WIDTH`: to FIFO `data_in`
- `wr_en` out 1: to FIFO `wr_en`
- `wr_ack` in 1, `overflow` in 1, `full` in 1: from FIFO; registered FIFO responses one cycle after `wr_en`
- `busy` out 1: high in any state other than IDLE
- `acc_cnt` out `NUM_REQ*16`: per-requester accepted-word counters (present only with `FIFO_ARB_STATS_EN`)

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If any `req` and `!full`: pick the winner round-robin, searching from `ptr` upward with wrap.
  - Latch the winner index `idx` and its `req_data` into `wdata`, then go to ISSUE.
  - If `full`: stay in IDLE.
- ISSUE: drive `wr_en`=1 and `data_in`=`wdata` for exactly one cycle, then go to WAIT.
- WAIT:
  - `wr_ack`=1: `gnt[idx]`=1 this cycle (combinational from `wr_ack` and state); `ptr` ← (`idx`+1) mod `NUM_REQ`; go to IDLE.
  - `overflow`=1, or neither `wr_ack` nor `overflow`: go to HOLD with no grant. `idx`/`wdata` are kept, with no re-arbitration, so the same word is retried.
  - `wr_ack` and `overflow` both 1: treat as ack.
- HOLD: wait until `!full`, then go to ISSUE with the same `idx`/`wdata`.
- `wdata` is captured only in IDLE. A requester that changes its data or drops `req` after capture still has its latched word written and receives `gnt` only if `req` is still high; otherwise the `gnt` bit is suppressed. Dropping `req` after capture is a protocol violation.
- `ptr` changes only on ack. It is a `$clog2(NUM_REQ)`-bit register and wraps `NUM_REQ-1`→0.
- `wr_en` is never high in two consecutive cycles. `wr_en` and `gnt` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `ptr`=0, `idx`=0, `wdata`=0, `wr_en`=0, `data_in`=0, `gnt`=0, `busy`=0, `acc_cnt`=0.
- Clean write: `req` sampled in IDLE at cycle 0 → `wr_en` at cycle 1 → `wr_ack`/`gnt` at cycle 2 → IDLE at cycle 3. Peak throughput is 1 word per 3 cycles.
- Overflow retry: the retry `wr_en` comes at the earliest 2 cycles after the overflow cycle (HOLD → ISSUE), once `full` is low.
- `rst` asserted mid-transaction: return to IDLE immediately. The in-flight word is abandoned without a `gnt`; the requester keeps `req` high and is re-arbitrated from `ptr`=0.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - `acc_cnt` port and counters exist.
  - `acc_cnt[i]` increments on each `gnt[i]` and wraps 0xFFFF→0.
  - Counters are cleared by `rst` only.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Structure
- Package `fifo_arb_pkg`: state enum (IDLE, ISSUE, WAIT, HOLD) and `CNT_W`=16.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are `req` and `ptr`; outputs are the one-hot `win` and the index `win_idx`. It is instantiated once, in the FSM's IDLE decode.

## Test plan
- Single write: `req`=0001, `req_data[0]`=0xA5A5, FIFO empty → `wr_en` at cycle 1 with `data_in`=0xA5A5; `gnt`=0001 at cycle 2.
- Fairness: `req`=1111 held, FIFO never full → grants in order 0001, 0010, 0100, 1000, 0001, one grant every 3 cycles.
- Overflow retry: FIFO returns `overflow`=1 for word 0x1234 from requester 2, with `full`=1 for 4 cycles → no `gnt`, HOLD while full, same 0x1234 re-issued, then `gnt`=0100.
- Full at arbitration: `full`=1 with `req`=0011 → `wr_en` stays 0 and `busy`=0; on `full`↓ requester 0 is issued first.
- Reset mid-op: `rst` pulsed in the WAIT cycle → no `gnt`; all outputs return to reset values. After `rst`↓, requester 3's held request is re-issued and granted.
- `FIFO_ARB_STATS_EN`: 5 grants to requester 1 → `acc_cnt[1]`=5, others 0. Preload to 0xFFFF and grant once more → 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: FSM state encodings and counter width.
// The optional per-requester statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    localparam int CNT_W = 16;

    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping
// modulo NUM_REQ. Produces both a one-hot winner and its index.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // The extra sum bit lets ptr+i exceed NUM_REQ-1 before folding back.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found        = 1'b1;
                win[cand]    = 1'b1;
                win_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; retries on overflow so no word is lost.
// Define FIFO_ARB_STATS_EN to add the per-requester accepted-word counters (acc_cnt).
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [FIFO_WIDTH-1:0]         data_in,
    output logic                          wr_en,
    input  logic                          wr_ack,
    input  logic                          overflow,
    input  logic                          full,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]      acc_cnt,
    output logic                          busy
`else
    output logic                          busy
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FIFO_WIDTH-1:0] wdata_q, wdata_d;

    logic [NUM_REQ-1:0]    win;
    logic [IDX_W-1:0]      win_idx;
    logic [FIFO_WIDTH-1:0] win_word;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_word = win_word | req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // idx/wdata are frozen outside IDLE so an overflow retry re-issues the same word.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if ((|req) && !full) begin
                    idx_d   = win_idx;
                    wdata_d = win_word;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wr_ack) begin
                    ptr_d   = (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!full) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    // A requester that dropped req after capture still gets its word written, but no grant.
    always_comb begin
        gnt = '0;
        if (state_q == WAIT && wr_ack) begin
            gnt[idx_q] = req[idx_q];
        end
    end

    assign wr_en   = (state_q == ISSUE);
    assign data_in = (state_q == ISSUE) ? wdata_q : '0;
    assign busy    = (state_q != IDLE);

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_cnt_d[i] = acc_cnt_q[i] + CNT_W'(gnt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_cnt = acc_cnt_q;
`else
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter; the FIFO side is driven by hand.
// Covers the statistics counters too when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   data_in;
    logic           wr_en;
    logic           wr_ack;
    logic           overflow;
    logic           full;
    logic           busy;
`ifdef FIFO_ARB_STATS_EN
    logic [N*16-1:0] acc_cnt;
`endif

    int num_checks;
    int num_fails;

    fifo_wr_arbiter #(
        .FIFO_WIDTH (W),
        .NUM_REQ    (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .wr_ack   (wr_ack),
        .overflow (overflow),
        .full     (full),
`ifdef FIFO_ARB_STATS_EN
        .acc_cnt  (acc_cnt),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input int slot, input logic [W-1:0] word);
        req_data[slot*W +: W] = word;
        req = r;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        wr_ack   = 1'b0;
        overflow = 1'b0;
        full     = 1'b0;
        tick();
        checkOutput("rst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("rst_gnt", 64'(gnt), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_data_in", 64'(data_in), 64'd0);
        rst = 1'b0;
    endtask

    // Starting in IDLE with a request pending: ISSUE, WAIT+ack, back to IDLE.
    task automatic runWrite(input string tag, input logic [N-1:0] exp_gnt,
                            input logic [W-1:0] exp_data, input bit drop_req);
        #1;
        checkOutput({tag, "_idle_wr_en"}, 64'(wr_en), 64'd0);
        tick();
        checkOutput({tag, "_wr_en"}, 64'(wr_en), 64'd1);
        checkOutput({tag, "_data"}, 64'(data_in), 64'(exp_data));
        checkOutput({tag, "_no_gnt_issue"}, 64'(gnt), 64'd0);
        tick();
        wr_ack = 1'b1;
        #1;
        checkOutput({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        checkOutput({tag, "_wait_wr_en"}, 64'(wr_en), 64'd0);
        tick();
        wr_ack = 1'b0;
        if (drop_req) req = req & ~exp_gnt;
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        num_checks = 0;
        num_fails  = 0;
        req        = '0;
        req_data   = '0;
        wr_ack     = 1'b0;
        overflow   = 1'b0;
        full       = 1'b0;

        // Single write from requester 0
        doReset();
        applyStimulus(4'b0001, 0, 16'hA5A5);
        runWrite("single", 4'b0001, 16'hA5A5, 1'b1);
        checkOutput("single_back_idle", 64'(busy), 64'd0);

        // Fairness with all four requesting, wrap from 3 back to 0
        doReset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'h1000 + 16'(i);
        req = 4'b1111;
        runWrite("rr0", 4'b0001, 16'h1000, 1'b0);
        runWrite("rr1", 4'b0010, 16'h1001, 1'b0);
        runWrite("rr2", 4'b0100, 16'h1002, 1'b0);
        runWrite("rr3", 4'b1000, 16'h1003, 1'b0);
        runWrite("rr4", 4'b0001, 16'h1000, 1'b0);

        // Overflow on requester 2, full held for four cycles, then retried
        doReset();
        applyStimulus(4'b0100, 2, 16'h1234);
        tick();
        checkOutput("ovf_issue_data", 64'(data_in), 64'h1234);
        tick();
        overflow = 1'b1;
        full     = 1'b1;
        #1;
        checkOutput("ovf_no_gnt", 64'(gnt), 64'd0);
        tick();
        overflow = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("ovf_hold_wr_en", 64'(wr_en), 64'd0);
            checkOutput("ovf_hold_busy", 64'(busy), 64'd1);
            tick();
        end
        full = 1'b0;
        #1;
        checkOutput("ovf_hold_last_wr_en", 64'(wr_en), 64'd0);
        tick();
        checkOutput("ovf_retry_wr_en", 64'(wr_en), 64'd1);
        checkOutput("ovf_retry_data", 64'(data_in), 64'h1234);
        tick();
        wr_ack = 1'b1;
        #1;
        checkOutput("ovf_gnt", 64'(gnt), 64'b0100);
        tick();
        wr_ack = 1'b0;
        req    = '0;

        // Full while arbitrating: nothing issued until full drops
        doReset();
        full = 1'b1;
        applyStimulus(4'b0011, 0, 16'h00AA);
        applyStimulus(4'b0011, 1, 16'h00BB);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("full_wr_en", 64'(wr_en), 64'd0);
            checkOutput("full_busy", 64'(busy), 64'd0);
        end
        full = 1'b0;
        runWrite("full_first", 4'b0001, 16'h00AA, 1'b1);
        runWrite("full_second", 4'b0010, 16'h00BB, 1'b1);

        // Reset in the WAIT cycle abandons the word; requester 3 is re-served afterwards
        doReset();
        applyStimulus(4'b1000, 3, 16'hBEEF);
        tick();
        tick();
        wr_ack = 1'b1;
        rst    = 1'b1;
        #1;
        checkOutput("midrst_gnt", 64'(gnt), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_wr_en", 64'(wr_en), 64'd0);
        checkOutput("midrst_data_in", 64'(data_in), 64'd0);
        tick();
        rst    = 1'b0;
        wr_ack = 1'b0;
        runWrite("midrst_reissue", 4'b1000, 16'hBEEF, 1'b1);

        // Requester drops req after capture: word still written, grant suppressed
        doReset();
        applyStimulus(4'b0001, 0, 16'h5A5A);
        tick();
        req = '0;
        #1;
        checkOutput("drop_data", 64'(data_in), 64'h5A5A);
        tick();
        wr_ack = 1'b1;
        #1;
        checkOutput("drop_no_gnt", 64'(gnt), 64'd0);
        tick();
        wr_ack = 1'b0;
        checkOutput("drop_idle", 64'(busy), 64'd0);

`ifdef FIFO_ARB_STATS_EN
        // Five grants to requester 1 only
        doReset();
        checkOutput("stats_reset", 64'(acc_cnt), 64'd0);
        applyStimulus(4'b0010, 1, 16'h7777);
        for (int k = 0; k < 5; k++) runWrite("stats", 4'b0010, 16'h7777, 1'b0);
        req = '0;
        #1;
        checkOutput("stats_cnt", 64'(acc_cnt), 64'h0000_0000_0005_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
